// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: loads a parallel word, shifts it out serially while capturing serial_in, then pulses done
// Ports: clk, reset (sync, active-high); start/din/ready accept a transfer in IDLE;
//        serial_in/serial_out form the 1-bit link; busy covers SHIFT and DONE;
//        done pulses one cycle with dout holding the captured word.
module shift_reg_sequencer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    input  logic             serial_in,
    output logic             serial_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CW-1:0]    cnt;
    logic             last;
    always_comb begin
        shreg_nxt  = MSB_FIRST ? {shreg[WIDTH-2:0], serial_in} : {serial_in, shreg[WIDTH-1:1]};
        last       = cnt == CW'(WIDTH - 1);
        ready      = state == IDLE;
        busy       = state == SHIFT || state == DONE;
        done       = state == DONE;
        serial_out = state == SHIFT ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : 1'b0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            dout  <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                shreg <= din;
                cnt   <= '0;
                state <= SHIFT;
            end
        end else if (state == SHIFT) begin
            shreg <= shreg_nxt;
            // cnt returns to 0 on the last shift so it never exceeds WIDTH-1
            cnt   <= last ? '0 : cnt + 1'b1;
            if (last) begin
                dout  <= shreg_nxt;
                state <= DONE;
            end
        end else begin
            // DONE, or an unreachable encoding, always falls back to IDLE
            state <= IDLE;
        end
    end
endmodule
